// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with stall/flush/bubble handling and branch-slot PC tracking.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_stage_reg #(
    parameter int              XLEN      = 32,
    parameter int              PAYLOAD_W = 128,
    parameter int              STALL_W   = 6,
    parameter int              STAGE_IDX = 3,
    parameter logic [31:0]     NOP_INS   = 32'h00000013,
    parameter int              CNT_W     = 32
) (
    input  logic                 clk_i,
    input  logic                 n_rst_i,
    input  logic [STALL_W-1:0]   stall_i,
    input  logic                 flush_i,
    input  logic                 valid_i,
    input  logic [XLEN-1:0]      pc_i,
    input  logic [31:0]          ins_i,
    input  logic                 branch_tag_i,
    input  logic                 branch_slot_end_i,
    input  logic [PAYLOAD_W-1:0] payload_i,
    output logic                 valid_o,
    output logic [XLEN-1:0]      pc_o,
    output logic [31:0]          ins_o,
    output logic [PAYLOAD_W-1:0] payload_o,
    output logic                 in_slot_o,
    output logic [CNT_W-1:0]     bubble_cnt_o,
    output logic [CNT_W-1:0]     flush_cnt_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SLOT = 1'b1
    } slot_state_t;

    if (STAGE_IDX > STALL_W - 2) begin : g_param_err
        $error("pipe_stage_reg: STAGE_IDX must be <= STALL_W-2");
    end

    logic                 stall_self_s;
    logic                 stall_down_s;
    logic                 flush_s;
    logic                 bubble_s;
    logic                 advance_s;
    logic                 stall_unused_s;

    logic                 valid_r;
    logic [XLEN-1:0]      pc_r;
    logic [31:0]          ins_r;
    logic [PAYLOAD_W-1:0] payload_r;
    slot_state_t          state_r;
    logic [XLEN-1:0]      branch_pc_r;

    assign stall_self_s   = stall_i[STAGE_IDX];
    assign stall_down_s   = stall_i[STAGE_IDX+1];
    assign stall_unused_s = ^stall_i;

    // Decode the per-edge action; flush dominates, then bubble, then advance, else hold.
    always_comb begin
        flush_s   = 1'b0;
        bubble_s  = 1'b0;
        advance_s = 1'b0;
        if (flush_i) begin
            flush_s = 1'b1;
        end else if (stall_self_s && !stall_down_s) begin
            // Downstream keeps moving while we stall, so it must see an empty slot.
            bubble_s = 1'b1;
        end else if (!stall_self_s) begin
            advance_s = 1'b1;
        end else begin
            flush_s   = 1'b0;
        end
    end

    // Datapath registers and branch-slot FSM.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            valid_r     <= 1'b0;
            pc_r        <= {XLEN{1'b0}};
            ins_r       <= NOP_INS;
            payload_r   <= {PAYLOAD_W{1'b0}};
            state_r     <= ST_IDLE;
            branch_pc_r <= {XLEN{1'b0}};
        end else if (flush_s || bubble_s) begin
            valid_r   <= 1'b0;
            pc_r      <= {XLEN{1'b0}};
            ins_r     <= NOP_INS;
            payload_r <= {PAYLOAD_W{1'b0}};
            state_r   <= ST_IDLE;
            if (flush_s) begin
                branch_pc_r <= {XLEN{1'b0}};
            end else begin
                branch_pc_r <= branch_pc_r;
            end
        end else if (advance_s) begin
            valid_r   <= valid_i;
            ins_r     <= ins_i;
            payload_r <= payload_i;
            // Instructions inside a branch slot report the owning branch's PC.
            pc_r      <= (state_r == ST_SLOT) ? branch_pc_r : pc_i;
            case (state_r)
                ST_IDLE: begin
                    if (branch_tag_i) begin
                        state_r     <= ST_SLOT;
                        branch_pc_r <= pc_i;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_SLOT: begin
                    // A new branch re-opens the slot even when it also ends the old one.
                    if (branch_tag_i) begin
                        state_r     <= ST_SLOT;
                        branch_pc_r <= pc_i;
                    end else if (branch_slot_end_i) begin
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_SLOT;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    branch_pc_r <= {XLEN{1'b0}};
                end
            endcase
        end else begin
            valid_r     <= valid_r;
            pc_r        <= pc_r;
            ins_r       <= ins_r;
            payload_r   <= payload_r;
            state_r     <= state_r;
            branch_pc_r <= branch_pc_r;
        end
    end

    assign valid_o   = valid_r;
    assign pc_o      = pc_r;
    assign ins_o     = ins_r;
    assign payload_o = payload_r;
    assign in_slot_o = (state_r == ST_SLOT);

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] bubble_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // Saturating bubble/flush event counters.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            bubble_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            if (bubble_s && (bubble_cnt_r != {CNT_W{1'b1}})) begin
                bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                bubble_cnt_r <= bubble_cnt_r;
            end
            if (flush_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
                flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign bubble_cnt_o = bubble_cnt_r;
    assign flush_cnt_o  = flush_cnt_r;
`else
    assign bubble_cnt_o = {CNT_W{1'b0}};
    assign flush_cnt_o  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (works with or without PIPE_PERF_CNT_EN).
module tb_pipe_stage_reg;

    localparam int XLEN      = 32;
    localparam int PAYLOAD_W = 16;
    localparam int STALL_W   = 6;
    localparam int CNT_W     = 3;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic                 clk_s = 1'b0;
    logic                 n_rst_s;
    logic [STALL_W-1:0]   stall_s;
    logic                 flush_s;
    logic                 valid_in_s;
    logic [XLEN-1:0]      pc_in_s;
    logic [31:0]          ins_in_s;
    logic                 tag_s;
    logic                 slot_end_s;
    logic [PAYLOAD_W-1:0] payload_in_s;
    logic                 valid_out_s;
    logic [XLEN-1:0]      pc_out_s;
    logic [31:0]          ins_out_s;
    logic [PAYLOAD_W-1:0] payload_out_s;
    logic                 in_slot_s;
    logic [CNT_W-1:0]     bubble_cnt_s;
    logic [CNT_W-1:0]     flush_cnt_s;

    int checks_r = 0;
    int errors_r = 0;

    pipe_stage_reg #(
        .XLEN(XLEN), .PAYLOAD_W(PAYLOAD_W), .STALL_W(STALL_W), .STAGE_IDX(3),
        .NOP_INS(32'h00000013), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk_s), .n_rst_i(n_rst_s), .stall_i(stall_s), .flush_i(flush_s),
        .valid_i(valid_in_s), .pc_i(pc_in_s), .ins_i(ins_in_s),
        .branch_tag_i(tag_s), .branch_slot_end_i(slot_end_s), .payload_i(payload_in_s),
        .valid_o(valid_out_s), .pc_o(pc_out_s), .ins_o(ins_out_s), .payload_o(payload_out_s),
        .in_slot_o(in_slot_s), .bubble_cnt_o(bubble_cnt_s), .flush_cnt_o(flush_cnt_s)
    );

    always #5 clk_s = ~clk_s;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_s);
        @(negedge clk_s);
    endtask

    task automatic drive(input logic [STALL_W-1:0] st, input logic fl, input logic v,
                         input logic [31:0] pc, input logic [31:0] ins,
                         input logic tg, input logic se, input logic [15:0] pl);
        stall_s = st; flush_s = fl; valid_in_s = v; pc_in_s = pc; ins_in_s = ins;
        tag_s = tg; slot_end_s = se; payload_in_s = pl;
    endtask

    function automatic logic [63:0] perf_exp(input int n);
        if (!PERF) return 64'd0;
        return (n > 7) ? 64'd7 : 64'(n);
    endfunction

    initial begin
        n_rst_s = 1'b0;
        drive(6'b000000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0);
        #12;
        check_val("rst_valid",   {63'd0, valid_out_s}, 64'd0);
        check_val("rst_ins",     {32'd0, ins_out_s},   64'h13);
        check_val("rst_pc",      {32'd0, pc_out_s},    64'd0);
        check_val("rst_payload", {48'd0, payload_out_s}, 64'd0);
        check_val("rst_in_slot", {63'd0, in_slot_s},   64'd0);
        @(negedge clk_s);
        n_rst_s = 1'b1;

        // Plain advance
        drive(6'b000000, 1'b0, 1'b1, 32'h100, 32'h00A00093, 1'b0, 1'b0, 16'hBEEF);
        step();
        check_val("adv_pc",      {32'd0, pc_out_s},    64'h100);
        check_val("adv_ins",     {32'd0, ins_out_s},   64'h00A00093);
        check_val("adv_valid",   {63'd0, valid_out_s}, 64'd1);
        check_val("adv_payload", {48'd0, payload_out_s}, 64'hBEEF);

        // Bubble at stall boundary
        drive(6'b001111, 1'b0, 1'b1, 32'h104, 32'h12345678, 1'b0, 1'b0, 16'h1111);
        step();
        check_val("bub_valid",   {63'd0, valid_out_s}, 64'd0);
        check_val("bub_ins",     {32'd0, ins_out_s},   64'h13);
        check_val("bub_pc",      {32'd0, pc_out_s},    64'd0);
        check_val("bub_payload", {48'd0, payload_out_s}, 64'd0);
        check_val("bub_cnt1",    {61'd0, bubble_cnt_s}, perf_exp(1));

        // Load a real instruction, then hold it for 3 cycles
        drive(6'b000000, 1'b0, 1'b1, 32'h108, 32'h00B00113, 1'b0, 1'b0, 16'h2222);
        step();
        drive(6'b011111, 1'b0, 1'b0, 32'h999, 32'hFFFFFFFF, 1'b1, 1'b0, 16'h3333);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("hold_pc",    {32'd0, pc_out_s},     64'h108);
            check_val("hold_ins",   {32'd0, ins_out_s},    64'h00B00113);
            check_val("hold_valid", {63'd0, valid_out_s},  64'd1);
            check_val("hold_slot",  {63'd0, in_slot_s},    64'd0);
            check_val("hold_bcnt",  {61'd0, bubble_cnt_s}, perf_exp(1));
        end

        // Branch slot tracking
        drive(6'b000000, 1'b0, 1'b1, 32'h200, 32'h0, 1'b1, 1'b0, 16'h0);
        step();
        check_val("br0_pc",   {32'd0, pc_out_s},  64'h200);
        check_val("br0_slot", {63'd0, in_slot_s}, 64'd1);
        drive(6'b000000, 1'b0, 1'b1, 32'h204, 32'h0, 1'b0, 1'b0, 16'h0);
        step();
        check_val("br1_pc",   {32'd0, pc_out_s},  64'h200);
        drive(6'b000000, 1'b0, 1'b1, 32'h208, 32'h0, 1'b0, 1'b0, 16'h0);
        step();
        check_val("br2_pc",   {32'd0, pc_out_s},  64'h200);
        check_val("br2_slot", {63'd0, in_slot_s}, 64'd1);
        drive(6'b000000, 1'b0, 1'b1, 32'h300, 32'h0, 1'b0, 1'b1, 16'h0);
        step();
        check_val("br3_pc",   {32'd0, pc_out_s},  64'h200);
        check_val("br3_slot", {63'd0, in_slot_s}, 64'd0);
        drive(6'b000000, 1'b0, 1'b1, 32'h304, 32'h0, 1'b0, 1'b0, 16'h0);
        step();
        check_val("br4_pc",   {32'd0, pc_out_s},  64'h304);

        // Self-loop: tag and slot_end together
        drive(6'b000000, 1'b0, 1'b1, 32'h400, 32'h0, 1'b1, 1'b1, 16'h0);
        step();
        check_val("loop_pc",   {32'd0, pc_out_s},  64'h400);
        check_val("loop_slot", {63'd0, in_slot_s}, 64'd1);
        drive(6'b000000, 1'b0, 1'b1, 32'h404, 32'h0, 1'b1, 1'b1, 16'h0);
        step();
        check_val("loop2_pc",   {32'd0, pc_out_s},  64'h400);
        check_val("loop2_slot", {63'd0, in_slot_s}, 64'd1);
        drive(6'b000000, 1'b0, 1'b1, 32'h408, 32'h0, 1'b0, 1'b0, 16'h0);
        step();
        check_val("loop3_pc",   {32'd0, pc_out_s},  64'h404);

        // Flush while in SLOT, with own stall raised
        drive(6'b001000, 1'b1, 1'b1, 32'h500, 32'hAAAA5555, 1'b1, 1'b0, 16'h4444);
        step();
        check_val("fl_valid", {63'd0, valid_out_s},  64'd0);
        check_val("fl_pc",    {32'd0, pc_out_s},     64'd0);
        check_val("fl_slot",  {63'd0, in_slot_s},    64'd0);
        check_val("fl_fcnt",  {61'd0, flush_cnt_s},  perf_exp(1));
        check_val("fl_bcnt",  {61'd0, bubble_cnt_s}, perf_exp(1));
        drive(6'b000000, 1'b0, 1'b1, 32'h600, 32'h0, 1'b0, 1'b0, 16'h0);
        step();
        check_val("postfl_pc", {32'd0, pc_out_s}, 64'h600);

        // Advance with valid_i=0 still moves the FSM
        drive(6'b000000, 1'b0, 1'b0, 32'h700, 32'h0, 1'b1, 1'b0, 16'h0);
        step();
        check_val("inv_valid", {63'd0, valid_out_s}, 64'd0);
        check_val("inv_slot",  {63'd0, in_slot_s},   64'd1);

        // Counter saturation (3-bit counters)
        for (int i = 0; i < 8; i++) begin
            drive(6'b001000, 1'b0, 1'b1, 32'h800, 32'h0, 1'b0, 1'b0, 16'h0);
            step();
            drive(6'b000000, 1'b1, 1'b1, 32'h800, 32'h0, 1'b0, 1'b0, 16'h0);
            step();
        end
        check_val("sat_bcnt", {61'd0, bubble_cnt_s}, perf_exp(9));
        check_val("sat_fcnt", {61'd0, flush_cnt_s},  perf_exp(9));

        // Asynchronous reset in the middle of an advance
        drive(6'b000000, 1'b0, 1'b1, 32'h900, 32'h0badc0de, 1'b1, 1'b0, 16'h5555);
        step();
        check_val("pre_rst_valid", {63'd0, valid_out_s}, 64'd1);
        @(posedge clk_s);
        #2;
        n_rst_s = 1'b0;
        #1;
        check_val("mrst_valid", {63'd0, valid_out_s},  64'd0);
        check_val("mrst_ins",   {32'd0, ins_out_s},    64'h13);
        check_val("mrst_pc",    {32'd0, pc_out_s},     64'd0);
        check_val("mrst_slot",  {63'd0, in_slot_s},    64'd0);
        check_val("mrst_bcnt",  {61'd0, bubble_cnt_s}, 64'd0);
        check_val("mrst_fcnt",  {61'd0, flush_cnt_s},  64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
        $finish;
    end

endmodule
